// File: rtl/uart_rx_os16.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_os16
// Description : UART receiver, 16x oversampling, 3-sample majority vote per
//               bit, optional parity, framing-error and break handling.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_os16 #(
  parameter int clk_freq   = 1000000,
  parameter int baud_rate  = 9600,
  parameter int parity_en  = 0,
  parameter int parity_odd = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rxData,
  output logic       doneRx,
  output logic       parityErr,
  output logic       frameErr,
  output logic       busy
);

  localparam int   c_div     = (clk_freq / (baud_rate * 16) > 0) ? clk_freq / (baud_rate * 16) : 1;
  localparam int   c_pw      = (c_div > 1) ? $clog2(c_div) : 1;
  localparam logic c_par_en  = (parity_en != 0);
  localparam logic c_par_odd = (parity_odd != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic            rx_meta_q, rx_s_q, rx_prev_q;
  logic [c_pw-1:0] pcnt_q, pcnt_d;
  logic [3:0]      scnt_q, scnt_d;
  logic [2:0]      bidx_q, bidx_d;
  logic [7:0]      shift_q, shift_d;
  logic            s7_q, s7_d, s8_q, s8_d;
  logic            pmis_q, pmis_d;
  logic [7:0]      rxdata_q, rxdata_d;
  logic            done_q, done_d;
  logic            perr_q, perr_d;
  logic            ferr_q, ferr_d;
  logic            busy_q, busy_d;

  logic            w_tick;
  logic [3:0]      w_scnt_nxt;
  logic            w_fall;
  logic            w_vote;
  logic            w_par_exp;

  // The scnt value a tick advances to is the sample index that tick stands
  // for, so index 9 lands 9 ticks after the start edge (bit centre ~8).
  assign w_tick     = (pcnt_q == c_pw'(c_div - 1));
  assign w_scnt_nxt = scnt_q + 4'd1;
  assign w_fall     = rx_prev_q & ~rx_s_q;
  assign w_vote     = (s7_q & s8_q) | (s7_q & rx_s_q) | (s8_q & rx_s_q);
  assign w_par_exp  = (^shift_q) ^ c_par_odd;

  assign rxData     = rxdata_q;
  assign doneRx     = done_q;
  assign parityErr  = perr_q;
  assign frameErr   = ferr_q;
  assign busy       = busy_q;

  // State register, synchronizer, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
      pcnt_q    <= '0;
      scnt_q    <= '0;
      bidx_q    <= '0;
      shift_q   <= '0;
      s7_q      <= 1'b1;
      s8_q      <= 1'b1;
      pmis_q    <= 1'b0;
      rxdata_q  <= '0;
      done_q    <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
      pcnt_q    <= pcnt_d;
      scnt_q    <= scnt_d;
      bidx_q    <= bidx_d;
      shift_q   <= shift_d;
      s7_q      <= s7_d;
      s8_q      <= s8_d;
      pmis_q    <= pmis_d;
      rxdata_q  <= rxdata_d;
      done_q    <= done_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state logic: bit timing, vote capture, frame sequencing and pulses.
  always_comb begin
    state_d  = state_q;
    pcnt_d   = w_tick ? '0 : pcnt_q + c_pw'(1);
    scnt_d   = w_tick ? w_scnt_nxt : scnt_q;
    bidx_d   = bidx_q;
    shift_d  = shift_q;
    s7_d     = (w_tick && w_scnt_nxt == 4'd7) ? rx_s_q : s7_q;
    s8_d     = (w_tick && w_scnt_nxt == 4'd8) ? rx_s_q : s8_q;
    pmis_d   = pmis_q;
    rxdata_d = rxdata_q;
    done_d   = 1'b0;
    perr_d   = 1'b0;
    ferr_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (w_fall) begin
          // Realign bit timing to the detected start edge.
          state_d = S_START;
          pcnt_d  = '0;
          scnt_d  = '0;
          bidx_d  = '0;
          pmis_d  = 1'b0;
        end
      end
      S_START: begin
        if (w_tick && w_scnt_nxt == 4'd9 && w_vote) begin
          state_d = S_IDLE;
        end else if (w_tick && w_scnt_nxt == 4'd15) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (w_tick && w_scnt_nxt == 4'd9) begin
          shift_d = {w_vote, shift_q[7:1]};
        end
        if (w_tick && w_scnt_nxt == 4'd15) begin
          if (bidx_q == 3'd7) begin
            state_d = c_par_en ? S_PARITY : S_STOP;
          end else begin
            bidx_d = bidx_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (w_tick && w_scnt_nxt == 4'd9) begin
          pmis_d = (w_vote != w_par_exp);
        end
        if (w_tick && w_scnt_nxt == 4'd15) begin
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        // Decide at the stop-bit centre so a following start edge is seen.
        if (w_tick && w_scnt_nxt == 4'd9) begin
          if (w_vote) begin
            rxdata_d = shift_q;
            done_d   = 1'b1;
            perr_d   = pmis_q;
            state_d  = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // Any low sample restarts the one-tick high qualification window.
        if (!rx_s_q) begin
          pcnt_d = '0;
        end else if (w_tick) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_os16.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_os16
// Description : Directed self-checking bench for uart_rx_os16 (default and
//               even-parity instances).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_os16;

  localparam int BIT = 96;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic       rxp = 1'b1;
  logic [7:0] rxData, rxDataP;
  logic       doneRx, parityErr, frameErr, busy;
  logic       doneRxP, parityErrP, frameErrP, busyP;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int n_done0 = 0, n_ferr0 = 0, n_perr0 = 0, n_busy0 = 0;
  int n_done1 = 0, n_ferr1 = 0, n_perr1 = 0, n_coinc1 = 0;
  int n_long  = 0;
  logic prev_d0 = 0, prev_f0 = 0, prev_d1 = 0, prev_p1 = 0;
  logic [7:0] q_data0[$];
  int         q_t0[$];
  int         t_edge = 0;

  uart_rx_os16 u_dut (
    .clk(clk), .rst(rst), .rx(rx), .rxData(rxData), .doneRx(doneRx),
    .parityErr(parityErr), .frameErr(frameErr), .busy(busy)
  );

  uart_rx_os16 #(.parity_en(1), .parity_odd(0)) u_dutp (
    .clk(clk), .rst(rst), .rx(rxp), .rxData(rxDataP), .doneRx(doneRxP),
    .parityErr(parityErrP), .frameErr(frameErrP), .busy(busyP)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse and busy monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (doneRx) begin
      n_done0++;
      q_data0.push_back(rxData);
      q_t0.push_back(cyc);
    end
    if (frameErr)  n_ferr0++;
    if (parityErr) n_perr0++;
    if (busy)      n_busy0++;
    if (doneRxP)   n_done1++;
    if (frameErrP) n_ferr1++;
    if (parityErrP) n_perr1++;
    if (parityErrP && doneRxP) n_coinc1++;
    if ((doneRx && prev_d0) || (frameErr && prev_f0) || (doneRxP && prev_d1) || (parityErrP && prev_p1))
      n_long++;
    prev_d0 = doneRx;
    prev_f0 = frameErr;
    prev_d1 = doneRxP;
    prev_p1 = parityErrP;
  end

  task automatic drive_bit(input bit sel, input logic v, input int n);
    if (sel) rxp = v; else rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input bit has_par,
                            input logic par, input logic stop);
    t_edge = cyc;
    drive_bit(sel, 1'b0, BIT);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i], BIT);
    if (has_par) drive_bit(sel, par, BIT);
    drive_bit(sel, stop, BIT);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    rx  = 1'b1;
    rxp = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (rxData !== 8'h00) begin errors++; $display("FAIL reset_rxData: got %h expected 00", rxData); end
    checks++; if ({doneRx, parityErr, frameErr, busy} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {doneRx, parityErr, frameErr, busy}); end
    checks++; if ({rxDataP, doneRxP, busyP} !== 10'h000) begin
      errors++; $display("FAIL reset_par_dut: got %h expected 000", {rxDataP, doneRxP, busyP}); end
    rst = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_basic;
    int d0, b0, lat;
    d0 = n_done0; b0 = n_busy0;
    send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    checks++; if (n_done0 - d0 !== 1) begin errors++; $display("FAIL basic_done_count: got %0d expected 1", n_done0 - d0); end
    checks++; if (rxData !== 8'hA5) begin errors++; $display("FAIL basic_rxData: got %h expected a5", rxData); end
    checks++; if (n_ferr0 + n_perr0 !== 0) begin errors++; $display("FAIL basic_err_pulses: got %0d expected 0", n_ferr0 + n_perr0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b expected 0", busy); end
    lat = (q_t0.size() > 0) ? q_t0[q_t0.size()-1] - t_edge : -1;
    checks++; if (lat < 914 || lat > 926) begin errors++; $display("FAIL basic_latency: got %0d expected 920+-6", lat); end
    checks++; if (n_busy0 - b0 < 912 || n_busy0 - b0 > 924) begin
      errors++; $display("FAIL basic_busy_len: got %0d expected ~918", n_busy0 - b0); end
  endtask

  task automatic test_frame_error;
    int d0, f0;
    d0 = n_done0; f0 = n_ferr0;
    t_edge = cyc;
    drive_bit(1'b0, 1'b0, BIT);
    for (int i = 0; i < 8; i++) drive_bit(1'b0, ((8'h3C >> i) & 8'h01) != 0, BIT);
    drive_bit(1'b0, 1'b0, 200);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL break_busy_held: got %b expected 1", busy); end
    drive_bit(1'b0, 1'b0, 100);
    drive_bit(1'b0, 1'b1, 200);
    checks++; if (n_ferr0 - f0 !== 1) begin errors++; $display("FAIL ferr_count: got %0d expected 1", n_ferr0 - f0); end
    checks++; if (n_done0 - d0 !== 0) begin errors++; $display("FAIL ferr_no_done: got %0d expected 0", n_done0 - d0); end
    checks++; if (rxData !== 8'hA5) begin errors++; $display("FAIL ferr_rxData_kept: got %h expected a5", rxData); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL break_busy_exit: got %b expected 0", busy); end
    send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    checks++; if (n_done0 - d0 !== 1) begin errors++; $display("FAIL after_break_done: got %0d expected 1", n_done0 - d0); end
    checks++; if (rxData !== 8'h5A) begin errors++; $display("FAIL after_break_rxData: got %h expected 5a", rxData); end
  endtask

  task automatic test_false_start_glitch;
    int d0, f0;
    d0 = n_done0; f0 = n_ferr0;
    drive_bit(1'b0, 1'b0, 20);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL false_start_busy: got %b expected 1", busy); end
    drive_bit(1'b0, 1'b1, 76);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL false_start_idle: got %b expected 0", busy); end
    checks++; if ((n_done0 - d0) + (n_ferr0 - f0) !== 0) begin
      errors++; $display("FAIL false_start_pulses: got %0d expected 0", (n_done0 - d0) + (n_ferr0 - f0)); end
    repeat (100) @(negedge clk);
    drive_bit(1'b0, 1'b0, BIT);
    drive_bit(1'b0, 1'b1, 3 * BIT + 48);
    drive_bit(1'b0, 1'b0, 1);
    drive_bit(1'b0, 1'b1, 47 + 4 * BIT + BIT + 20);
    checks++; if (n_done0 - d0 !== 1) begin errors++; $display("FAIL glitch_done: got %0d expected 1", n_done0 - d0); end
    checks++; if (rxData !== 8'hFF) begin errors++; $display("FAIL glitch_rxData: got %h expected ff", rxData); end
  endtask

  task automatic test_parity;
    int d1, p1, c1;
    d1 = n_done1; p1 = n_perr1; c1 = n_coinc1;
    send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    checks++; if (n_done1 - d1 !== 1) begin errors++; $display("FAIL par_ok_done: got %0d expected 1", n_done1 - d1); end
    checks++; if (n_perr1 - p1 !== 0) begin errors++; $display("FAIL par_ok_perr: got %0d expected 0", n_perr1 - p1); end
    checks++; if (rxDataP !== 8'h07) begin errors++; $display("FAIL par_ok_rxData: got %h expected 07", rxDataP); end
    send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    checks++; if (n_done1 - d1 !== 2) begin errors++; $display("FAIL par_bad_done: got %0d expected 2", n_done1 - d1); end
    checks++; if (n_coinc1 - c1 !== 1 || n_perr1 - p1 !== 1) begin
      errors++; $display("FAIL par_bad_perr: got coinc %0d total %0d expected 1 1", n_coinc1 - c1, n_perr1 - p1); end
    checks++; if (rxDataP !== 8'h07) begin errors++; $display("FAIL par_bad_rxData: got %h expected 07", rxDataP); end
  endtask

  task automatic test_back_to_back;
    int d0, n, dt;
    d0 = n_done0;
    send_frame(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    send_frame(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    n = q_data0.size();
    checks++; if (n_done0 - d0 !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d expected 2", n_done0 - d0); end
    if (n >= 2) begin
      dt = q_t0[n-1] - q_t0[n-2];
      checks++; if (q_data0[n-2] !== 8'h00 || q_data0[n-1] !== 8'hFF) begin
        errors++; $display("FAIL b2b_data: got %h %h expected 00 ff", q_data0[n-2], q_data0[n-1]); end
      checks++; if (dt < 954 || dt > 966) begin errors++; $display("FAIL b2b_spacing: got %0d expected ~960", dt); end
    end
  endtask

  task automatic test_reset_midframe;
    int d0;
    d0 = n_done0;
    drive_bit(1'b0, 1'b0, BIT);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, ((8'h81 >> i) & 8'h01) != 0, BIT);
    drive_bit(1'b0, 1'b0, 48);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b expected 1", busy); end
    #2 rst = 1'b0;
    #1;
    checks++; if (rxData !== 8'h00 || busy !== 1'b0) begin
      errors++; $display("FAIL async_reset: got rxData %h busy %b expected 00 0", rxData, busy); end
    rx = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (1000) @(negedge clk);
    checks++; if (n_done0 - d0 !== 0) begin errors++; $display("FAIL aborted_pulse: got %0d expected 0", n_done0 - d0); end
    send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    checks++; if (n_done0 - d0 !== 1) begin errors++; $display("FAIL post_reset_done: got %0d expected 1", n_done0 - d0); end
    checks++; if (rxData !== 8'h81) begin errors++; $display("FAIL post_reset_rxData: got %h expected 81", rxData); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_frame_error();
    test_false_start_glitch();
    test_parity();
    test_back_to_back();
    test_reset_midframe();
    checks++; if (n_long !== 0) begin errors++; $display("FAIL pulse_width: got %0d long pulses expected 0", n_long); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
